// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
// Packet-control state machine for the 1-in/3-out router. It decodes the
// 2-bit header address, sequences the header, payload and parity loads, stalls
// while the addressed FIFO is full, and waits for a busy destination FIFO to
// drain before it accepts a packet for it.
//
// Ports
//   clock               system clock, rising edge
//   reset               synchronous, active-high
//   pkt_valid           high for header and payload bytes, low on the parity byte
//   data_in[1:0]        header address field
//   fifo_full           full flag of the currently addressed FIFO
//   fifo_empty_0..2     per-FIFO empty flags
//   soft_reset_0..2     per-FIFO timeout soft resets
//   parity_done         register stage has captured the parity byte
//   low_pkt_valid       register stage saw pkt_valid fall while stalled
//   detect_add          state == DECODE_ADDRESS
//   lfd_state           state == LOAD_FIRST_DATA
//   ld_state            state == LOAD_DATA
//   laf_state           state == LOAD_AFTER_FULL
//   full_state          state == FIFO_FULL_STATE
//   write_enb_reg       state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
//   rst_int_reg         state == CHECK_PARITY_ERROR
//   busy                high except in DECODE_ADDRESS and LOAD_DATA
// -----------------------------------------------------------------------------
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic [1:0] w_idx;
  logic       w_hdr_ok;
  logic       w_tgt_empty;
  logic       w_tgt_soft;

  logic r_detect_add;
  logic r_lfd_state;
  logic r_ld_state;
  logic r_laf_state;
  logic r_full_state;
  logic r_write_enb_reg;
  logic r_rst_int_reg;
  logic r_busy;

  // A header with address 3 is not a valid destination and is ignored.
  assign w_hdr_ok = pkt_valid && (data_in != 2'b11);

  // While decoding, the header on the bus selects the FIFO; afterwards the
  // captured address does, so the source may move on to payload bytes.
  assign w_idx = (r_state == DECODE_ADDRESS) ? data_in : r_addr;

  always_comb begin
    w_tgt_empty = 1'b1;
    w_tgt_soft  = 1'b0;
    case (w_idx)
      2'd0: begin
        w_tgt_empty = fifo_empty_0;
        w_tgt_soft  = soft_reset_0;
      end
      2'd1: begin
        w_tgt_empty = fifo_empty_1;
        w_tgt_soft  = soft_reset_1;
      end
      2'd2: begin
        w_tgt_empty = fifo_empty_2;
        w_tgt_soft  = soft_reset_2;
      end
      default: begin
        w_tgt_empty = 1'b1;
        w_tgt_soft  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    // A destination timeout abandons the packet from any active state.
    if ((r_state != DECODE_ADDRESS) && w_tgt_soft) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (w_hdr_ok) w_next = w_tgt_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: w_next = LOAD_DATA;
        LOAD_DATA: begin
          // Full wins over the pkt_valid fall; low_pkt_valid remembers the fall.
          if (fifo_full)       w_next = FIFO_FULL_STATE;
          else if (!pkt_valid) w_next = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) w_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        w_next = DECODE_ADDRESS;
          else if (low_pkt_valid) w_next = LOAD_PARITY;
          else                    w_next = LOAD_DATA;
        end
        LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (w_tgt_empty) w_next = LOAD_FIRST_DATA;
        end
        default: w_next = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next state so each one is a clean decode
  // of the state register with no combinational path from the inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= DECODE_ADDRESS;
      r_addr          <= 2'd0;
      r_detect_add    <= 1'b1;
      r_lfd_state     <= 1'b0;
      r_ld_state      <= 1'b0;
      r_laf_state     <= 1'b0;
      r_full_state    <= 1'b0;
      r_write_enb_reg <= 1'b0;
      r_rst_int_reg   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == DECODE_ADDRESS) && w_hdr_ok) r_addr <= data_in;
      r_detect_add    <= (w_next == DECODE_ADDRESS);
      r_lfd_state     <= (w_next == LOAD_FIRST_DATA);
      r_ld_state      <= (w_next == LOAD_DATA);
      r_laf_state     <= (w_next == LOAD_AFTER_FULL);
      r_full_state    <= (w_next == FIFO_FULL_STATE);
      r_write_enb_reg <= (w_next == LOAD_DATA) || (w_next == LOAD_PARITY) ||
                         (w_next == LOAD_AFTER_FULL);
      r_rst_int_reg   <= (w_next == CHECK_PARITY_ERROR);
      r_busy          <= !((w_next == DECODE_ADDRESS) || (w_next == LOAD_DATA));
    end
  end

  assign detect_add    = r_detect_add;
  assign lfd_state     = r_lfd_state;
  assign ld_state      = r_ld_state;
  assign laf_state     = r_laf_state;
  assign full_state    = r_full_state;
  assign write_enb_reg = r_write_enb_reg;
  assign rst_int_reg   = r_rst_int_reg;
  assign busy          = r_busy;

endmodule

// File: tb/tb_router_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_fsm
// Directed bench for router_fsm. Outputs are packed into one byte
// {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} and compared
// against hand-written per-state patterns.
// -----------------------------------------------------------------------------
module tb_router_fsm;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output byte per state
  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0100;
  localparam logic [7:0] E_LP  = 8'b0000_0101;
  localparam logic [7:0] E_FUL = 8'b0000_1001;
  localparam logic [7:0] E_LAF = 8'b0001_0101;
  localparam logic [7:0] E_WTE = 8'b0000_0001;
  localparam logic [7:0] E_CPE = 8'b0000_0011;

  router_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drop pkt_valid and the register-stage flags, then wait (bounded) for
  // the machine to come home to DECODE_ADDRESS.
  task automatic drain(input string tag);
    int k;
    pkt_valid     = 1'b0;
    low_pkt_valid = 1'b0;
    parity_done   = 1'b0;
    fifo_full     = 1'b0;
    k = 0;
    while (!detect_add && k < 8) begin
      step();
      k++;
    end
    chk(tag, outs(), E_DA);
  endtask

  // Header to addr, one payload cycle, stall on full, release, then check the
  // LOAD_AFTER_FULL exit chosen by low_pkt_valid / parity_done.
  task automatic run_full(input logic [1:0] addr, input logic drop_pv,
                          input logic lpv, input logic pd,
                          input logic [7:0] exp_next, input string tag);
    pkt_valid = 1'b1;
    data_in   = addr;
    step();  chk({tag, "_lfd"}, outs(), E_LFD);
    step();  chk({tag, "_ld"},  outs(), E_LD);
    fifo_full = 1'b1;
    if (drop_pv) pkt_valid = 1'b0;
    step();  chk({tag, "_full"},  outs(), E_FUL);
    step();  chk({tag, "_full2"}, outs(), E_FUL);
    fifo_full = 1'b0;
    step();  chk({tag, "_laf"}, outs(), E_LAF);
    low_pkt_valid = lpv;
    parity_done   = pd;
    step();  chk({tag, "_next"}, outs(), exp_next);
    drain({tag, "_home"});
  endtask

  initial begin
    int web_cnt;
    int rst_cnt;
    reset = 1'b1;  pkt_valid = 1'b0;  data_in = 2'd0;  fifo_full = 1'b0;
    fifo_empty_0 = 1'b1;  fifo_empty_1 = 1'b1;  fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0;  soft_reset_1 = 1'b0;  soft_reset_2 = 1'b0;
    parity_done = 1'b0;  low_pkt_valid = 1'b0;
    step();
    step();
    chk("reset_outs", outs(), E_DA);
    reset = 1'b0;
    step();
    chk("idle", outs(), E_DA);

    // Normal packet to FIFO 1, four payload cycles
    web_cnt = 0;  rst_cnt = 0;
    pkt_valid = 1'b1;  data_in = 2'd1;
    step();  chk("p1_lfd", outs(), E_LFD);
    data_in = 2'd3;  // payload bits must not matter now
    for (int i = 0; i < 4; i++) begin
      step();  chk("p1_ld", outs(), E_LD);
      web_cnt += int'(write_enb_reg);
    end
    pkt_valid = 1'b0;
    step();  chk("p1_lp", outs(), E_LP);
    web_cnt += int'(write_enb_reg);
    step();  chk("p1_cpe", outs(), E_CPE);
    rst_cnt += int'(rst_int_reg);
    web_cnt += int'(write_enb_reg);
    step();  chk("p1_da", outs(), E_DA);
    rst_cnt += int'(rst_int_reg);
    chk("p1_web_cycles", web_cnt, 5);
    chk("p1_rst_pulse", rst_cnt, 1);

    // Stall variants: low_pkt_valid, plain resume, parity_done
    run_full(2'd0, 1'b1, 1'b1, 1'b0, E_LP,  "fl_lpv");
    run_full(2'd1, 1'b0, 1'b0, 1'b0, E_LD,  "fl_res");
    run_full(2'd2, 1'b0, 1'b0, 1'b1, E_DA,  "fl_pd");

    // CHECK_PARITY_ERROR with fifo_full goes back to FIFO_FULL_STATE
    pkt_valid = 1'b1;  data_in = 2'd1;
    step();  step();
    pkt_valid = 1'b0;
    step();  chk("cpf_lp", outs(), E_LP);
    step();  chk("cpf_cpe", outs(), E_CPE);
    fifo_full = 1'b1;
    step();  chk("cpf_full", outs(), E_FUL);
    drain("cpf_home");

    // Busy destination: wait for FIFO 2 to drain
    fifo_empty_2 = 1'b0;
    pkt_valid = 1'b1;  data_in = 2'd2;
    step();  chk("wte_enter", outs(), E_WTE);
    data_in = 2'd0;  // index now comes from the captured address
    fifo_empty_0 = 1'b0;
    step();  chk("wte_e0_lo", outs(), E_WTE);
    fifo_empty_0 = 1'b1;
    step();  chk("wte_e0_hi", outs(), E_WTE);
    fifo_empty_2 = 1'b1;
    step();  chk("wte_lfd", outs(), E_LFD);
    step();  chk("wte_ld", outs(), E_LD);
    drain("wte_home");

    // Soft reset: other port ignored, own port aborts
    pkt_valid = 1'b1;  data_in = 2'd0;
    step();  chk("sr_lfd", outs(), E_LFD);
    step();  chk("sr_ld", outs(), E_LD);
    soft_reset_1 = 1'b1;
    step();  chk("sr_other", outs(), E_LD);
    soft_reset_1 = 1'b0;
    soft_reset_0 = 1'b1;
    step();  chk("sr_abort", outs(), E_DA);
    soft_reset_0 = 1'b0;
    pkt_valid = 1'b0;
    step();  chk("sr_stay", outs(), E_DA);

    // Invalid header address 3
    pkt_valid = 1'b1;  data_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();  chk("inv_hdr", outs(), E_DA);
    end

    // Reset during FIFO_FULL_STATE
    data_in = 2'd1;
    step();  step();
    fifo_full = 1'b1;
    step();  chk("rf_full", outs(), E_FUL);
    reset = 1'b1;
    step();  chk("rf_reset", outs(), E_DA);
    reset = 1'b0;  pkt_valid = 1'b0;
    step();  chk("rf_stay", outs(), E_DA);
    fifo_full = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-control state machine for the 1-in/3-out router.
- Sits directly upstream of the write-enable/soft-reset synchronizer and alongside the register stage.
- Detects the 2-bit header address, sequences header/payload/parity loading, stalls on the destination FIFO full flag, and waits for the destination FIFO to drain.
- Drives detect_add and write_enb_reg to the synchronizer, and the load-phase strobes to the register stage.

Parameters:
- None. The design has three destination ports, a 2-bit address field, and address 2'b11 is invalid.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  source asserts for header+payload bytes, deasserts on the parity byte
- data_in  in  2  address field (header bits [1:0]) from the source bus
- fifo_full  in  1  full flag of the currently addressed FIFO (from synchronizer)
- fifo_empty_0  in  1  FIFO 0 empty
- fifo_empty_1  in  1  FIFO 1 empty
- fifo_empty_2  in  1  FIFO 2 empty
- soft_reset_0  in  1  timeout soft reset, FIFO 0
- soft_reset_1  in  1  timeout soft reset, FIFO 1
- soft_reset_2  in  1  timeout soft reset, FIFO 2
- parity_done  in  1  register stage has captured the parity byte
- low_pkt_valid  in  1  register stage saw pkt_valid fall while stalled
- detect_add  out  1  state==DECODE_ADDRESS
- lfd_state  out  1  state==LOAD_FIRST_DATA
- ld_state  out  1  state==LOAD_DATA
- laf_state  out  1  state==LOAD_AFTER_FULL
- full_state  out  1  state==FIFO_FULL_STATE
- write_enb_reg  out  1  state in {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL}
- rst_int_reg  out  1  state==CHECK_PARITY_ERROR
- busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA

Behaviour:
- Moore machine. All outputs decode only from the registered state; there are no input-to-output paths.
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- Reset: state is DECODE_ADDRESS and addr_q is 0.
  - Outputs after reset: detect_add=1, busy=0, all other outputs 0.
- addr_q (2-bit) loads data_in on a clock edge where state==DECODE_ADDRESS, pkt_valid=1 and data_in!=3. It holds otherwise.
- tgt_empty = fifo_empty_[addr] and tgt_soft = soft_reset_[addr].
  - In DECODE_ADDRESS these use data_in as the index. In all other states they use addr_q.
- Transitions, evaluated each rising edge in priority order:
  1. reset=1 -> DECODE_ADDRESS.
  2. state!=DECODE_ADDRESS and tgt_soft=1 -> DECODE_ADDRESS. This aborts the packet from any state.
  3. Per-state rules:
     - DECODE_ADDRESS:
       - pkt_valid and data_in!=3 and tgt_empty -> LOAD_FIRST_DATA
       - pkt_valid and data_in!=3 and !tgt_empty -> WAIT_TILL_EMPTY
       - otherwise stay. A data_in=3 header is ignored and no output pulses.
     - LOAD_FIRST_DATA -> LOAD_DATA unconditionally. This is a 1-cycle header load.
     - LOAD_DATA:
       - fifo_full -> FIFO_FULL_STATE
       - else !pkt_valid -> LOAD_PARITY
       - else stay. fifo_full has priority when it coincides with the pkt_valid fall.
     - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
     - LOAD_AFTER_FULL:
       - parity_done -> DECODE_ADDRESS
       - else low_pkt_valid -> LOAD_PARITY
       - else -> LOAD_DATA
     - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
     - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
     - WAIT_TILL_EMPTY: tgt_empty -> LOAD_FIRST_DATA; else stay.
- Latency:
  - Header accepted in DECODE_ADDRESS reaches lfd_state=1 on the next cycle and ld_state=1 one cycle after that.
  - busy is high during LOAD_FIRST_DATA, so the source must hold the first payload byte for that cycle.
- State encoding is implementer's choice. Unreachable encodings must recover to DECODE_ADDRESS.

Test Plan:
- Reset held 2 cycles -> detect_add=1, busy=0, write_enb_reg=0, rst_int_reg=0.
- Empty FIFO 1: pkt_valid=1, data_in=01, 4 payload cycles, then pkt_valid=0 -> state sequence DECODE, LFD, LD×4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE.
  - write_enb_reg high 5 cycles.
  - rst_int_reg pulses 1 cycle.
- fifo_full=1 mid-payload -> full_state=1, busy=1, write_enb_reg=0 until fifo_full=0.
  - Then laf_state=1 for 1 cycle.
  - Run once with low_pkt_valid=1 -> next state LOAD_PARITY.
  - Run once with both 0 -> next state LOAD_DATA.
  - Run once with parity_done=1 -> next state DECODE_ADDRESS.
- fifo_empty_2=0 with header data_in=10 -> WAIT_TILL_EMPTY, busy=1.
  - Drop fifo_empty_2 to 1 -> lfd_state=1 the following cycle.
  - Toggling fifo_empty_0 has no effect.
- soft_reset_0=1 while in LOAD_DATA for addr 0 -> DECODE_ADDRESS the next cycle.
  - soft_reset_1 asserted while addressing port 0 has no effect.
- Header data_in=11 with pkt_valid=1 -> stays in DECODE_ADDRESS, lfd_state never asserts.
  - Reset asserted during FIFO_FULL_STATE -> DECODE_ADDRESS the next cycle regardless of fifo_full.
